mlt3_lane_encoder: RTL and testbench

Parametrised multi-lane MLT-3 line encoder with a built-in serializer and a selectable NRZI mode. It accepts parallel words over a valid/ready handshake and shifts them out one bit per lane per clock. Each lane is encoded into a 2-bit signed level for the line-driver stage. It is the next-generation replacement for the single-lane, ungated MLT-3 coder: lane count and word width are parametrised, reset is asynchronous, and input is flow-controlled.

---
 rtl/mlt3_lane_encoder.sv | 126 ++++++++++++
 tb/tb_mlt3_lane_encoder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mlt3_lane_encoder.sv
// Multi-lane MLT-3 / NRZI line encoder with an integrated LSB-first serializer.
// Words arrive over valid/ready; every lane emits one 2-bit signed level per falling edge.
module mlt3_lane_encoder #(
  parameter int LANES  = 1,
  parameter int WORD_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [WORD_W-1:0]    in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*LANES-1:0]   out_sym,
  output logic                 out_valid,
  output logic [2*LANES-1:0]   phase
);

  localparam int BPL = WORD_W / LANES;
  localparam int CW  = $clog2(BPL + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(BPL);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state_q, state_n;
  logic [CW-1:0]      cnt_q, cnt_n;
  logic [WORD_W-1:0]  shift_q, shift_n;
  logic               mode_q, mode_n;
  logic [2*LANES-1:0] sym_q, sym_n;
  logic [2*LANES-1:0] phase_q, phase_n;
  logic               accept;
  logic               enc;
  logic               enc_mode;
  logic [LANES-1:0]   enc_bits;
  logic [1:0]         ph_inc;

  // cnt_q counts symbols still to be shown, including the one on the line now,
  // so a new word may land on the same edge that retires the last slot.
  assign in_ready  = (cnt_q == '0) || (cnt_q == CNT_ONE);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state_q == SHIFT);
  assign out_sym   = sym_q;
  assign phase     = phase_q;

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    shift_n  = shift_q;
    mode_n   = mode_q;
    enc      = 1'b0;
    enc_mode = mode_q;
    enc_bits = shift_q[LANES-1:0];
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_n  = SHIFT;
          cnt_n    = CNT_FULL;
          shift_n  = in_data >> LANES;
          mode_n   = mode;
          enc      = 1'b1;
          enc_mode = mode;
          enc_bits = in_data[LANES-1:0];
        end
      end
      SHIFT: begin
        if (accept) begin
          cnt_n    = CNT_FULL;
          shift_n  = in_data >> LANES;
          mode_n   = mode;
          enc      = 1'b1;
          enc_mode = mode;
          enc_bits = in_data[LANES-1:0];
        end else if (cnt_q > CNT_ONE) begin
          cnt_n    = cnt_q - CNT_ONE;
          shift_n  = shift_q >> LANES;
          enc      = 1'b1;
        end else begin
          cnt_n    = '0;
          state_n  = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // A 1 bit advances the lane phase; the new phase picks the level.
  always_comb begin
    sym_n   = sym_q;
    phase_n = phase_q;
    ph_inc  = '0;
    for (int l = 0; l < LANES; l++) begin
      ph_inc = phase_q[2*l +: 2] + 2'd1;
      if (enc && enc_bits[l]) begin
        phase_n[2*l +: 2] = ph_inc;
        if (enc_mode) begin
          sym_n[2*l +: 2] = ph_inc[0] ? 2'b10 : 2'b01;
        end else begin
          case (ph_inc)
            2'd1:    sym_n[2*l +: 2] = 2'b10;
            2'd3:    sym_n[2*l +: 2] = 2'b01;
            default: sym_n[2*l +: 2] = 2'b00;
          endcase
        end
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shift_q <= '0;
      mode_q  <= 1'b0;
      sym_q   <= '0;
      phase_q <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      shift_q <= shift_n;
      mode_q  <= mode_n;
      sym_q   <= sym_n;
      phase_q <= phase_n;
    end
  end

endmodule

// File: tb/tb_mlt3_lane_encoder.sv
// Scoreboard bench for mlt3_lane_encoder (2 lanes, 8-bit words): a word-level
// reference model queues expected symbols at accept; a monitor pops and compares.
module tb_mlt3_lane_encoder;

  localparam int LANES  = 2;
  localparam int WORD_W = 8;
  localparam int BPL    = WORD_W / LANES;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               mode = 1'b0;
  logic               in_valid = 1'b0;
  logic [WORD_W-1:0]  in_data = '0;
  logic               in_ready;
  logic               out_valid;
  logic [2*LANES-1:0] out_sym;
  logic [2*LANES-1:0] phase;

  mlt3_lane_encoder #(.LANES(LANES), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_sym(out_sym), .out_valid(out_valid), .phase(phase)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2*LANES-1:0] sym;
    logic [2*LANES-1:0] ph;
  } exp_t;

  exp_t expq[$];
  exp_t cur = '0;
  int   mph[LANES];
  int   mlvl[LANES];
  int   mrem = 0;
  int   nCompared = 0;
  int   nMismatched = 0;

  function automatic logic [1:0] levelCode(int v);
    if (v == 1) return 2'b10;
    if (v == -1) return 2'b01;
    return 2'b00;
  endfunction

  function automatic exp_t snapshot();
    exp_t s;
    s = '0;
    for (int l = 0; l < LANES; l++) begin
      s.sym[2*l +: 2] = levelCode(mlvl[l]);
      s.ph[2*l +: 2]  = 2'(mph[l]);
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mrem = 0;
    for (int l = 0; l < LANES; l++) begin
      mph[l]  = 0;
      mlvl[l] = 0;
    end
    expq.delete();
    cur = '0;
  endtask

  // Reference model: on acceptance the whole word is encoded at once.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && mrem <= 1) begin
        for (int k = 0; k < BPL; k++) begin
          for (int l = 0; l < LANES; l++) begin
            if (in_data[l + LANES*k]) begin
              mph[l] = (mph[l] + 1) % 4;
              if (mode) mlvl[l] = (mph[l] % 2 == 1) ? 1 : -1;
              else      mlvl[l] = (mph[l] == 1) ? 1 : ((mph[l] == 3) ? -1 : 0);
            end
          end
          expq.push_back(snapshot());
        end
        mrem = BPL;
      end else if (mrem > 0) begin
        mrem--;
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready", 32'(in_ready), 32'(mrem <= 1));
      checkOutput("out_valid", 32'(out_valid), 32'(mrem > 0));
      if (mrem > 0) begin
        if (expq.size() == 0) begin
          nCompared++;
          nMismatched++;
          $display("[TB] FAIL scoreboard_underflow: got empty queue, expected a symbol at %0t", $time);
        end else begin
          cur = expq.pop_front();
        end
      end
      checkOutput("out_sym", 32'(out_sym), 32'(cur.sym));
      checkOutput("phase", 32'(phase), 32'(cur.ph));
    end
  end

  // Called at rising edge + 1; returns at the rising edge + 1 after acceptance.
  task automatic applyStimulus(input logic [WORD_W-1:0] data, input logic m);
    int tries;
    tries    = 0;
    in_valid = 1'b1;
    in_data  = data;
    mode     = m;
    while (!in_ready && tries < 64) begin
      @(posedge clk); #1;
      tries++;
    end
    if (!in_ready) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL handshake_timeout: got in_ready=0, expected 1 within 64 cycles");
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected $finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    modelReset();
    #3;
    checkOutput("reset_out_sym", 32'(out_sym), 32'd0);
    checkOutput("reset_phase", 32'(phase), 32'd0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    applyStimulus(8'h5F, 1'b0);
    idle(5);
    checkOutput("phase_after_5f", 32'(phase), 32'h8);

    applyStimulus(8'h0D, 1'b1);
    applyStimulus(8'hFF, 1'b0);
    applyStimulus(8'h00, 1'b0);
    applyStimulus(8'hB3, 1'b1);
    idle(6);

    for (int i = 0; i < 150; i++) begin
      applyStimulus(8'($urandom), 1'($urandom_range(0, 1)));
      idle($urandom_range(0, 2));
    end
    idle(6);

    in_valid = 1'b1;
    in_data  = 8'hFF;
    mode     = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    idle(2);
    #1;
    rst_n = 1'b0;
    modelReset();
    #1;
    checkOutput("midreset_out_sym", 32'(out_sym), 32'd0);
    checkOutput("midreset_phase", 32'(phase), 32'd0);
    checkOutput("midreset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("midreset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(8'h01, 1'b0);
    checkOutput("post_reset_first_slot", 32'(out_sym), 32'h2);
    idle(8);
    checkOutput("queue_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
